// File: rtl/store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: DM op encodings and sizing defaults.
package store_buffer_pkg;

    localparam int DMOP_LEN = 3;
    localparam int SB_DEPTH = 4;

    typedef enum logic [DMOP_LEN-1:0] {
        DM_W = 3'd0,
        DM_H = 3'd1,
        DM_B = 3'd2,
        DM_L = 3'd3,
        DM_R = 3'd4
    } dm_op_e;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry storage for the store buffer: head/tail/count pointers, head read,
// and a per-slot valid mask so the top level can match loads against every pending entry.
module store_buffer_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [W-1:0] entries [DEPTH],
    output logic [DEPTH-1:0] valid,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [W-1:0]  mem [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: entry payloads are deliberately not reset; the valid mask derived from count guards them.
    always_ff @(posedge clock) begin
        if (push) mem[tail] <= wdata;
    end

    // Slot i is live when its distance from head (mod DEPTH) is below count.
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = {1'b0, PW'(i) - head} < count;
        end
    end

    assign entries = mem;
    assign rdata   = mem[head];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of the single-port DM: queues stores, drains one per idle
// port cycle, and stalls any load whose word matches a pending store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int AW    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [AW-1:0]       st_addr,
    input  logic [DMOP_LEN-1:0] st_op,
    input  logic [31:0]         st_wd,
    input  logic [31:0]         st_pc,
    input  logic                ld_valid,
    input  logic [AW-1:0]       ld_addr,
    input  logic [DMOP_LEN-1:0] ld_op,
    output logic                ld_stall,
    output logic                dm_wr,
    output logic [AW-1:0]       dm_a,
    output logic [DMOP_LEN-1:0] dm_op,
    output logic [31:0]         dm_wd,
    output logic [31:0]         dm_pc,
    output logic                empty
);
    localparam int EW = AW + DMOP_LEN + 64;

    logic [EW-1:0]    head_q;
    logic [EW-1:0]    entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] hit;
    logic             full;
    logic             push;
    logic             drain;

    assign st_ready = !full;
    assign push     = st_valid && st_ready;

    store_buffer_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (drain),
        .wdata   ({st_addr, st_op, st_wd, st_pc}),
        .rdata   (head_q),
        .entries (entries),
        .valid   (valid),
        .full    (full),
        .empty   (empty)
    );

    // Word-granular match: conservative for byte/half ops, registered entries only.
    always_comb begin
        hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i] = valid[i] && (entries[i][EW-1 -: AW-2] == ld_addr[AW-1:2]);
        end
    end

    assign ld_stall = ld_valid && (|hit);
    assign drain    = !empty && (!ld_valid || ld_stall);

    always_comb begin
        dm_wr = 1'b0;
        dm_a  = ld_addr;
        dm_op = ld_op;
        dm_wd = '0;
        dm_pc = '0;
        if (drain) begin
            dm_wr = 1'b1;
            dm_a  = head_q[EW-1 -: AW];
            dm_op = head_q[64 +: DMOP_LEN];
            dm_wd = head_q[32 +: 32];
            dm_pc = head_q[0 +: 32];
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based model of the posted-write rules.
module tb_store_buffer;
    import store_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        st_valid = 1'b0;
    logic        st_ready;
    logic [31:0] st_addr = '0;
    logic [2:0]  st_op = '0;
    logic [31:0] st_wd = '0;
    logic [31:0] st_pc = '0;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [2:0]  ld_op = '0;
    logic        ld_stall;
    logic        dm_wr;
    logic [31:0] dm_a;
    logic [2:0]  dm_op;
    logic [31:0] dm_wd;
    logic [31:0] dm_pc;
    logic        empty;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  op;
        logic [31:0] wd;
        logic [31:0] pc;
    } st_t;

    st_t q[$];

    store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .st_valid (st_valid),
        .st_ready (st_ready),
        .st_addr  (st_addr),
        .st_op    (st_op),
        .st_wd    (st_wd),
        .st_pc    (st_pc),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_op    (ld_op),
        .ld_stall (ld_stall),
        .dm_wr    (dm_wr),
        .dm_a     (dm_a),
        .dm_op    (dm_op),
        .dm_wd    (dm_wd),
        .dm_pc    (dm_pc),
        .empty    (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [2:0] so,
                         input logic [31:0] swd, input logic [31:0] spc,
                         input logic lv, input logic [31:0] la, input logic [2:0] lo);
        st_valid = sv; st_addr = sa; st_op = so; st_wd = swd; st_pc = spc;
        ld_valid = lv; ld_addr = la; ld_op = lo;
    endtask

    // Called just after a falling edge with inputs applied: checks outputs, then advances the model at the rising edge.
    task automatic cycle();
        logic exp_stall;
        logic exp_drain;
        logic exp_ready;
        #1;
        exp_stall = 1'b0;
        foreach (q[i]) if (ld_valid && q[i].addr[31:2] == ld_addr[31:2]) exp_stall = 1'b1;
        exp_drain = (q.size() > 0) && (!ld_valid || exp_stall);
        exp_ready = q.size() < DEPTH;
        check("st_ready", 32'(st_ready), 32'(exp_ready));
        check("empty",    32'(empty),    32'(q.size() == 0));
        check("ld_stall", 32'(ld_stall), 32'(exp_stall));
        check("dm_wr",    32'(dm_wr),    32'(exp_drain));
        if (exp_drain) begin
            check("dm_a_st",  dm_a,        q[0].addr);
            check("dm_op_st", 32'(dm_op),  32'(q[0].op));
            check("dm_wd_st", dm_wd,       q[0].wd);
            check("dm_pc_st", dm_pc,       q[0].pc);
        end else begin
            check("dm_a_ld",  dm_a,        ld_addr);
            check("dm_op_ld", 32'(dm_op),  32'(ld_op));
            check("dm_wd_ld", dm_wd,       32'h0);
            check("dm_pc_ld", dm_pc,       32'h0);
        end
        @(posedge clock);
        if (exp_drain) void'(q.pop_front());
        if (st_valid && exp_ready) q.push_back('{addr: st_addr, op: st_op, wd: st_wd, pc: st_pc});
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 32'h0, 3'(DM_W), 32'h0, 32'h0, 1'b0, 32'h0, 3'(DM_W));
            cycle();
        end
    endtask

    initial begin
        // Reset held two cycles with a store presented: nothing may be queued.
        drive(1'b1, 32'h40, 3'(DM_W), 32'h11111111, 32'h400, 1'b0, 32'h0, 3'(DM_W));
        reset = 1'b0;
        @(negedge clock);
        #1;
        check("rst_empty",    32'(empty),    32'h1);
        check("rst_st_ready", 32'(st_ready), 32'h1);
        check("rst_dm_wr",    32'(dm_wr),    32'h0);
        check("rst_ld_stall", 32'(ld_stall), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        idle(2);

        // Single store on an idle port retires the next cycle.
        drive(1'b1, 32'h10, 3'(DM_W), 32'hDEADBEEF, 32'h1000, 1'b0, 32'h0, 3'(DM_W));
        cycle();
        idle(2);

        // Fill while loads hog the port, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h200 + 32'(i*4), 3'(DM_W), 32'hA0 + 32'(i), 32'h2000 + 32'(i*4),
                  1'b1, 32'h100, 3'(DM_L));
            cycle();
        end
        drive(1'b1, 32'h300, 3'(DM_W), 32'hBAD, 32'h3000, 1'b1, 32'h100, 3'(DM_L));
        cycle();
        idle(DEPTH + 1);

        // Byte store to 0x23 then a conflicting word load to 0x20.
        drive(1'b1, 32'h23, 3'(DM_B), 32'h5A, 32'h4000, 1'b0, 32'h0, 3'(DM_W));
        cycle();
        drive(1'b0, 32'h0, 3'(DM_W), 32'h0, 32'h0, 1'b1, 32'h20, 3'(DM_W));
        cycle();
        cycle();
        idle(1);

        // Push and pop in the same cycle at count=2.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h500 + 32'(i*4), 3'(DM_H), 32'hC0 + 32'(i), 32'h5000 + 32'(i*4),
                  1'b1, 32'h600, 3'(DM_L));
            cycle();
        end
        drive(1'b1, 32'h508, 3'(DM_H), 32'hC2, 32'h5008, 1'b0, 32'h0, 3'(DM_W));
        cycle();
        idle(4);

        // Reset asserted mid-drain with 3 pending entries.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h700 + 32'(i*4), 3'(DM_W), 32'hE0 + 32'(i), 32'h7000 + 32'(i*4),
                  1'b1, 32'h800, 3'(DM_L));
            cycle();
        end
        drive(1'b0, 32'h0, 3'(DM_W), 32'h0, 32'h0, 1'b0, 32'h0, 3'(DM_W));
        #3;
        reset = 1'b0;
        #1;
        check("mid_rst_empty", 32'(empty), 32'h1);
        check("mid_rst_dm_wr", 32'(dm_wr), 32'h0);
        q.delete();
        @(negedge clock);
        reset = 1'b1;
        idle(3);

        // Random traffic over a small address window to provoke frequent conflicts.
        for (int n = 0; n < 600; n++) begin
            logic sv;
            logic lv;
            sv = ($urandom_range(0, 2) == 0);
            lv = ($urandom_range(0, 1) == 1);
            if (sv && lv && $urandom_range(0, 7) != 0) lv = 1'b0;
            drive(sv, 32'($urandom_range(0, 31)), 3'($urandom_range(0, 4)), $urandom(), $urandom(),
                  lv, 32'($urandom_range(0, 31)), 3'($urandom_range(0, 4)));
            cycle();
        end
        idle(DEPTH + 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the MEM-stage pipeline register and the single-port `DM`. Stores are accepted in one cycle and queued in order. They drain into `DM` one per cycle whenever the pipeline is not using the DM port for a load. A load that touches a word with a pending store stalls until that store has retired, so loads never return stale data.

## Interface
Parameters:
- `DEPTH`, 4: entries, power of two, ≥2.
- `AW`, 32: address width.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `st_valid`  in  1  MEM stage presents a store.
- `st_ready`  out  1  buffer can accept (`!full`).
- `st_addr`  in  AW  byte address.
- `st_op`  in  `DMOp_len`  `DM_w`/`DM_h`/`DM_b`/`DM_l`/`DM_r`.
- `st_wd`  in  32  store data, unshifted, as `DM` expects.
- `st_pc`  in  32  PC of the store, for the `DM` trace.
- `ld_valid`  in  1  MEM stage presents a load.
- `ld_addr`  in  AW  load byte address.
- `ld_op`  in  `DMOp_len`  load op.
- `ld_stall`  out  1  load conflicts with a pending entry; hold the pipeline.
- `dm_wr`  out  1  to `DM.DMWr`.
- `dm_a`  out  AW  to `DM.A`.
- `dm_op`  out  `DMOp_len`  to `DM.DMOp`.
- `dm_wd`  out  32  to `DM.WD`.
- `dm_pc`  out  32  to `DM.pc`.
- `empty`  out  1  no pending entries; used by syscall/eret sequencing.

## Operation
- Circular FIFO with registered head pointer, tail pointer and count (width log2(DEPTH)+1). Entry = {addr, op, wd, pc}.
- Push when `st_valid && st_ready`: write the entry at tail, tail+1 mod DEPTH.
- Drain condition: `count>0 && (!ld_valid || ld_stall)`.
  - `dm_wr=1`; `dm_a/op/wd/pc` = head entry.
  - Pop at the clock edge: head+1 mod DEPTH.
- Otherwise `dm_wr=0` and `dm_a=ld_addr`, `dm_op=ld_op`, `dm_wd=0`, `dm_pc=0`. The load reads `DM` combinationally this cycle.
- `ld_stall = ld_valid && any valid entry has addr[AW-1:2]==ld_addr[AW-1:2]`.
  - Word granularity, conservative for byte/half ops.
  - Compares registered entries only.
- While stalled, the drain proceeds, so the conflict clears in at most `count` cycles. No deadlock.
- Simultaneous push and pop: count unchanged, both pointers advance.
- `st_ready` depends only on registered count, never on same-cycle pop. Full stays full for that cycle.
- `st_valid && ld_valid` together is illegal (one memory op per instruction). If it occurs, the store is accepted and the load is treated as above.
- Outputs `st_ready`, `empty`, `ld_stall`, `dm_*` are combinational from registered state and current inputs. There are no internal combinational loops.

## Timing
- Reset (`reset`=0, async): count=0, head=tail=0, `empty`=1, `st_ready`=1, `dm_wr`=0, `ld_stall`=0. Entry contents need not be cleared.
- Reset mid-operation discards all pending stores. `DM` contents are not touched by this block.
- Push at edge N: the entry is at head from N. The earliest `DM` write is at edge N+1, if no load occupies the port.
- Minimum store-to-`DM` latency is 1 cycle. With back-to-back loads and no conflict, drain waits indefinitely.
- Throughput: 1 push and 1 drain per cycle.

## Structure
- `def.v` gains `` `SB_DEPTH `` (default 4) alongside the existing `` `DMOp_len `` and `` `DM_* `` op codes. No new op encodings.
- One natural sub-module is `sb_fifo`: pointer/count storage with push/pop/full/empty and head read.
- The top level holds the match comparators, drain arbitration and DM port mux.

## Test plan
- **Reset:** `reset`=0 for 2 cycles with `st_valid`=1 → `st_ready`=1, `empty`=1, `dm_wr`=0. Nothing is queued after release.
- **Single store, idle port:** `st_addr`=0x10, `DM_w`, `st_wd`=0xDEADBEEF, pushed at edge N → `dm_wr`=1 in cycle N+1, `dm_a`=0x10. Word 4 of `DM` reads 0xDEADBEEF after edge N+1, and `empty`=1.
- **Fill:** 4 stores while `ld_valid`=1 to 0x100 every cycle → `st_ready`=0 after the 4th push, `dm_wr`=0 throughout. Dropping `ld_valid` drains 4 entries in 4 consecutive cycles, in order.
- **Conflict:** a store of byte 0x5A to 0x23 is pending and `ld_valid` is presented with `ld_addr`=0x20 → `ld_stall`=1 and the drain proceeds. `ld_stall` falls the cycle after the pop, and the load reads 0x5A000000-merged data.
- **Push+pop same cycle at count=2** → count stays 2, and the order of the 3 stores retired to `DM` is preserved.
- **Reset mid-drain:** `reset` asserted with 3 pending entries → `empty`=1 immediately. No further `dm_wr` occurs after release.
